axil_cordic_master: RTL and testbench

AXI4-Lite master that runs one complete CORDIC job against the `axil` CORDIC slave: write angle, write start, poll status, read cos and sin. It gives on-chip logic a simple valid/ready request/response port, so no processor is needed to drive the accelerator. It sits between a user datapath and the `axil` slave's S_AXI port, on the same clock.

---
 rtl/axil_cordic_master.sv | 210 +++++++++++++++++++++
 tb/tb_axil_cordic_master.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_cordic_master.sv
// axil_cordic_master: AXI4-Lite master that sequences one CORDIC job
// (angle, start, status poll, cos, sin) behind a valid/ready port.
module axil_cordic_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int POLL_LIMIT = 1024
) (
  input  logic                  M_AXI_ACLK,
  input  logic                  M_AXI_ARESETN,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_angle,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_cos,
  output logic [31:0]           rsp_sin,
  output logic [1:0]            rsp_err,
  output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [31:0]           M_AXI_WDATA,
  output logic [3:0]            M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [31:0]           M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  localparam int CW = $clog2(POLL_LIMIT + 1);
  localparam logic [CW-1:0] POLL_MAX = CW'(POLL_LIMIT);
  localparam logic [31:0] DONE_WORD = 32'h0001_0000;
  localparam logic [ADDR_WIDTH-1:0] A_CTRL = ADDR_WIDTH'(4'h0);
  localparam logic [ADDR_WIDTH-1:0] A_ANG  = ADDR_WIDTH'(4'h4);
  localparam logic [ADDR_WIDTH-1:0] A_COS  = ADDR_WIDTH'(4'h8);
  localparam logic [ADDR_WIDTH-1:0] A_SIN  = ADDR_WIDTH'(4'hC);

  typedef enum logic [2:0] {
    IDLE,
    WR_ANGLE,
    WR_START,
    RD_STATUS,
    RD_COS,
    RD_SIN,
    RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] poll_cnt;
  logic [CW-1:0] poll_nxt;
  logic          aw_hs;
  logic          w_hs;
  logic          b_hs;
  logic          ar_hs;
  logic          r_hs;
  logic          b_bad;
  logic          r_bad;

  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
  assign b_hs  = M_AXI_BVALID && M_AXI_BREADY;
  assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_hs  = M_AXI_RVALID && M_AXI_RREADY;
  assign b_bad = (M_AXI_BRESP != 2'b00);
  assign r_bad = (M_AXI_RRESP != 2'b00);

  assign poll_nxt    = poll_cnt + CW'(1);
  assign req_ready   = (state == IDLE);
  assign M_AXI_WSTRB = 4'hF;

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state         <= IDLE;
      poll_cnt      <= '0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_cos       <= '0;
      rsp_sin       <= '0;
      rsp_err       <= '0;
    end else begin
      // Each VALID drops on its own handshake; phase code may re-raise it.
      if (aw_hs) M_AXI_AWVALID <= 1'b0;
      if (w_hs)  M_AXI_WVALID  <= 1'b0;
      if (ar_hs) M_AXI_ARVALID <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            rsp_err       <= 2'b00;
            poll_cnt      <= '0;
            M_AXI_AWADDR  <= A_ANG;
            M_AXI_WDATA   <= req_angle;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            M_AXI_BREADY  <= 1'b1;
            state         <= WR_ANGLE;
          end
        end
        WR_ANGLE: begin
          if (b_hs) begin
            M_AXI_BREADY  <= 1'b0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            if (b_bad) begin
              rsp_err   <= 2'b01;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              M_AXI_AWADDR  <= A_CTRL;
              M_AXI_WDATA   <= 32'd1;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              M_AXI_BREADY  <= 1'b1;
              state         <= WR_START;
            end
          end
        end
        WR_START: begin
          if (b_hs) begin
            M_AXI_BREADY  <= 1'b0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            if (b_bad) begin
              rsp_err   <= 2'b01;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              M_AXI_ARADDR  <= A_CTRL;
              M_AXI_ARVALID <= 1'b1;
              M_AXI_RREADY  <= 1'b1;
              state         <= RD_STATUS;
            end
          end
        end
        RD_STATUS: begin
          if (r_hs) begin
            M_AXI_RREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            if (r_bad) begin
              rsp_err   <= 2'b01;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else if (M_AXI_RDATA == DONE_WORD) begin
              M_AXI_ARADDR  <= A_COS;
              M_AXI_ARVALID <= 1'b1;
              M_AXI_RREADY  <= 1'b1;
              state         <= RD_COS;
            end else if (poll_nxt == POLL_MAX) begin
              poll_cnt  <= poll_nxt;
              rsp_err   <= 2'b10;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              poll_cnt      <= poll_nxt;
              M_AXI_ARVALID <= 1'b1;
              M_AXI_RREADY  <= 1'b1;
            end
          end
        end
        RD_COS: begin
          if (r_hs) begin
            M_AXI_RREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            if (r_bad) begin
              rsp_err   <= 2'b01;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              rsp_cos       <= M_AXI_RDATA;
              M_AXI_ARADDR  <= A_SIN;
              M_AXI_ARVALID <= 1'b1;
              M_AXI_RREADY  <= 1'b1;
              state         <= RD_SIN;
            end
          end
        end
        RD_SIN: begin
          if (r_hs) begin
            M_AXI_RREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            rsp_valid     <= 1'b1;
            state         <= RESP;
            if (r_bad) rsp_err <= 2'b01;
            else       rsp_sin <= M_AXI_RDATA;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_cordic_master.sv
// tb_axil_cordic_master: directed jobs against a behavioural AXI4-Lite
// slave, with results checked from an expected-response queue.
module tb_axil_cordic_master;

  localparam int AW = 4;
  localparam int PL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_ready;
  logic [31:0]   req_angle;
  logic          rsp_valid, rsp_ready;
  logic [31:0]   rsp_cos, rsp_sin;
  logic [1:0]    rsp_err;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready, arvalid, arready;
  logic          rvalid, rready;

  always #5 clk = ~clk;

  axil_cordic_master #(.ADDR_WIDTH(AW), .POLL_LIMIT(PL)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_angle(req_angle),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_cos(rsp_cos), .rsp_sin(rsp_sin), .rsp_err(rsp_err),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // slave knobs, driven by the stimulus
  int          aw_delay = 0;
  int          done_after = 1;
  bit          cos_err = 1'b0;
  logic [31:0] cos_word = '0;
  logic [31:0] sin_word = '0;

  // slave state and logs, owned by the model
  logic          aw_have, w_have, prev_wv;
  logic [AW-1:0] aw_q, wa;
  logic [31:0]   wd_q, wd, prev_wd;
  int            aw_wait, status_seen;
  logic [AW-1:0] wr_a_log [0:63];
  logic [31:0]   wr_d_log [0:63];
  logic [AW-1:0] rd_a_log [0:255];
  int wr_n = 0, rd_n = 0, aw_hi = 0, w_hi = 0, wstab = 0;

  assign awready = awvalid && !aw_have && (aw_wait >= aw_delay);
  assign wready  = wvalid && !w_have;
  assign arready = arvalid && !rvalid;
  assign wa = aw_have ? aw_q : awaddr;
  assign wd = w_have ? wd_q : wdata;

  always @(posedge clk) begin
    if (!rst_n) begin
      aw_have <= 1'b0; w_have <= 1'b0; aw_wait <= 0;
      bvalid <= 1'b0; bresp <= 2'b00;
      rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
      status_seen <= 0; prev_wv <= 1'b0; prev_wd <= '0;
    end else begin
      if (awvalid) aw_hi <= aw_hi + 1;
      if (wvalid) w_hi <= w_hi + 1;
      if (prev_wv && wvalid && wdata != prev_wd) wstab <= wstab + 1;
      prev_wv <= wvalid;
      prev_wd <= wdata;
      if (awvalid && !awready && !aw_have) aw_wait <= aw_wait + 1;
      if (awvalid && awready) begin
        aw_have <= 1'b1; aw_q <= awaddr; aw_wait <= 0;
      end
      if (wvalid && wready) begin
        w_have <= 1'b1; wd_q <= wdata;
      end
      if (!bvalid && (aw_have || (awvalid && awready))
          && (w_have || (wvalid && wready))) begin
        wr_a_log[wr_n] <= wa;
        wr_d_log[wr_n] <= wd;
        wr_n <= wr_n + 1;
        bvalid <= 1'b1;
        bresp <= 2'b00;
        if (wa == 4'h0 && wd == 32'd1) status_seen <= 0;
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0; aw_have <= 1'b0; w_have <= 1'b0;
      end
      if (arvalid && arready) begin
        rd_a_log[rd_n] <= araddr;
        rd_n <= rd_n + 1;
        rvalid <= 1'b1;
        rresp <= 2'b00;
        case (araddr)
          4'h0: begin
            status_seen <= status_seen + 1;
            rdata <= (done_after != 0 && status_seen + 1 >= done_after)
                     ? 32'h0001_0000 : 32'h0;
          end
          4'h8: begin
            rdata <= cos_word;
            if (cos_err) rresp <= 2'b10;
          end
          4'hC: rdata <= sin_word;
          default: rdata <= 32'h0;
        endcase
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  typedef struct {
    logic [31:0] c;
    logic [31:0] s;
    logic [1:0]  e;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   wb, rb, ab, wh;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] ang, input logic [31:0] ec,
                      input logic [31:0] es, input logic [1:0] ee);
    exp_t x;
    x.c = ec; x.s = es; x.e = ee;
    exp_q.push_back(x);
    @(negedge clk);
    req_valid = 1'b1;
    req_angle = ang;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    if (!req_ready) chk("req_ready_wait", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_angle = $urandom;
  endtask

  task automatic receive(input string tag, input int exp_lat);
    int   lat = 1;
    bit   got = 1'b0;
    exp_t x;
    for (int i = 0; i < 400; i++) begin
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_rsp_seen"}, 32'(got), 32'd1);
    x = exp_q.pop_front();
    if (got) begin
      chk({tag, "_cos"}, rsp_cos, x.c);
      chk({tag, "_sin"}, rsp_sin, x.s);
      chk({tag, "_err"}, 32'(rsp_err), 32'(x.e));
      if (exp_lat > 0) chk({tag, "_latency"}, lat, exp_lat);
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_idle_after"}, 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b0;
    req_angle = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_handshakes",
        32'({awvalid, wvalid, bready, arvalid, rready}), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_cos", rsp_cos, 32'd0);
    chk("rst_rsp_sin", rsp_sin, 32'd0);
    chk("rst_addrs", 32'({awaddr, araddr}), 32'd0);
    chk("rst_wstrb", 32'(wstrb), 32'hF);
    @(negedge clk);
    rst_n = 1'b1;

    // 45 degrees, zero-wait slave, done on first poll
    cos_word = 32'h3F35_04F3;
    sin_word = 32'h3F35_04F3;
    wb = wr_n; rb = rd_n;
    send(32'h4234_0000, 32'h3F35_04F3, 32'h3F35_04F3, 2'b00);
    receive("t45", 11);
    chk("t45_nwr", wr_n - wb, 2);
    chk("t45_wa0", 32'(wr_a_log[wb]), 32'h4);
    chk("t45_wd0", wr_d_log[wb], 32'h4234_0000);
    chk("t45_wa1", 32'(wr_a_log[wb+1]), 32'h0);
    chk("t45_wd1", wr_d_log[wb+1], 32'h1);
    chk("t45_nrd", rd_n - rb, 3);
    chk("t45_ra", 32'({rd_a_log[rb], rd_a_log[rb+1], rd_a_log[rb+2]}),
        32'h08C);

    // 90 degrees, done only on the third status read
    done_after = 3;
    cos_word = 32'h248D_3132;
    sin_word = 32'h3F80_0000;
    rb = rd_n;
    send(32'h42B4_0000, 32'h248D_3132, 32'h3F80_0000, 2'b00);
    receive("t90", 15);
    chk("t90_nrd", rd_n - rb, 5);

    // 180 degrees, AWREADY held off three cycles
    done_after = 1;
    aw_delay = 3;
    cos_word = 32'hBF80_0000;
    sin_word = 32'h250D_3132;
    wb = wr_n; ab = aw_hi; wh = w_hi;
    send(32'h4334_0000, 32'hBF80_0000, 32'h250D_3132, 2'b00);
    receive("t180", 17);
    chk("t180_nwr", wr_n - wb, 2);
    chk("t180_aw_cycles", aw_hi - ab, 8);
    chk("t180_w_cycles", w_hi - wh, 2);
    chk("t180_wdata_stable", wstab, 0);
    chk("t180_wd0", wr_d_log[wb], 32'h4334_0000);
    aw_delay = 0;

    // status never done: timeout after PL reads, old results held
    done_after = 0;
    cos_word = 32'hDEAD_0001;
    sin_word = 32'hDEAD_0002;
    rb = rd_n;
    send(32'h4120_0000, 32'hBF80_0000, 32'h250D_3132, 2'b10);
    receive("tmo", 0);
    chk("tmo_nrd", rd_n - rb, PL);
    chk("tmo_last_ra", 32'(rd_a_log[rd_n-1]), 32'h0);

    // bus error on the cos read: no sin read
    done_after = 1;
    cos_err = 1'b1;
    rb = rd_n;
    send(32'h41F0_0000, 32'hBF80_0000, 32'h250D_3132, 2'b01);
    receive("rerr", 0);
    chk("rerr_nrd", rd_n - rb, 2);
    chk("rerr_last_ra", 32'(rd_a_log[rd_n-1]), 32'h8);
    cos_err = 1'b0;

    // reset while a status read is in flight
    done_after = 0;
    send(32'h4270_0000, 32'h0, 32'h0, 2'b00);
    for (int i = 0; i < 50 && !arvalid; i++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_arvalid_seen", 32'(arvalid), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_arvalid", 32'(arvalid), 32'd0);
    chk("mid_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;

    // job after reset completes normally (30 degrees)
    done_after = 1;
    cos_word = 32'h3F5D_B3D7;
    sin_word = 32'h3F00_0000;
    send(32'h41F0_0000, 32'h3F5D_B3D7, 32'h3F00_0000, 2'b00);
    receive("t30", 11);
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
